// File: rtl/fetch_unit_if.sv
// fetch_unit_if -- instruction-fetch bus bundle.
//   master : the fetch unit (drives imem_addr, out_*, fetch_cnt, misalign_err)
//   slave  : memory + decode side (drives imem_rdata, redirect_*, out_ready)
// Signals:
//   imem_addr / imem_rdata      : combinational instruction memory read port
//   redirect_valid / redirect_pc: branch/jump redirect request and target
//   out_valid / out_ready       : IF/ID handshake
//   out_instr / out_pc / out_pc_plus4 : IF/ID payload
//   fetch_cnt                   : instructions accepted by decode
//   misalign_err                : sticky misaligned-redirect flag
interface fetch_unit_if #(
  parameter int W = 32
);
  logic [W-1:0] imem_addr;
  logic [W-1:0] imem_rdata;
  logic         redirect_valid;
  logic [W-1:0] redirect_pc;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_instr;
  logic [W-1:0] out_pc;
  logic [W-1:0] out_pc_plus4;
  logic [W-1:0] fetch_cnt;
  logic         misalign_err;

  modport master (
    output imem_addr, out_valid, out_instr, out_pc, out_pc_plus4,
           fetch_cnt, misalign_err,
    input  imem_rdata, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  imem_addr, out_valid, out_instr, out_pc, out_pc_plus4,
           fetch_cnt, misalign_err,
    output imem_rdata, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit -- single-stage instruction fetch with IF/ID register.
//   clk   : clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : fetch_unit_if.master (memory port, redirect, IF/ID handshake,
//           fetch counter, misalign flag)
// Parameters: RESET_PC (first fetch address), PROG_VALUE (addr/instr width;
// must match the interface width).
// Optional feature: define FETCH_MISALIGN_TRAP_EN to trap misaligned
// redirects (flag + HALT); otherwise the low two target bits are dropped.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          PROG_VALUE = 32
) (
  input  logic          clk,
  input  logic          reset,
  fetch_unit_if.master  bus
);
  localparam int W = PROG_VALUE;
  localparam logic [W-1:0] NOP = W'(32'h0000_0013);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t       state_q;
  logic [W-1:0] pc_q;
  logic         out_valid_q;
  logic [W-1:0] out_instr_q, out_pc_q, out_pc_plus4_q;
  logic [W-1:0] cnt_q;
  logic [W-1:0] pc_plus4_d;

  assign pc_plus4_d = pc_q + W'(4);  // wraps modulo 2^W by construction

`ifdef FETCH_MISALIGN_TRAP_EN
  logic err_q;
  assign bus.misalign_err = err_q;
`else
  // Low target bits are discarded in this build.
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^bus.redirect_pc[1:0];
  assign bus.misalign_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= BOOT;
      pc_q           <= W'(RESET_PC);
      out_valid_q    <= 1'b0;
      out_instr_q    <= NOP;
      out_pc_q       <= '0;
      out_pc_plus4_q <= '0;
      cnt_q          <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
      err_q          <= 1'b0;
`endif
    end else begin
      // Counts every accepted handshake, redirect cycles included.
      if (out_valid_q && bus.out_ready) cnt_q <= cnt_q + W'(1);

      unique case (state_q)
        BOOT: state_q <= RUN;  // one bubble cycle, no fetch
        RUN: begin
          if (bus.redirect_valid) begin
            // Redirect wins over stall and fetch: flush IF/ID, capture nothing.
            out_valid_q <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (bus.redirect_pc[1:0] != 2'b00) begin
              err_q   <= 1'b1;
              state_q <= HALT;
            end else begin
              pc_q <= bus.redirect_pc;
            end
`else
            pc_q <= {bus.redirect_pc[W-1:2], 2'b00};
`endif
          end else if (!out_valid_q || bus.out_ready) begin
            out_instr_q    <= bus.imem_rdata;
            out_pc_q       <= pc_q;
            out_pc_plus4_q <= pc_plus4_d;
            out_valid_q    <= 1'b1;
            pc_q           <= pc_plus4_d;
          end
        end
        HALT: ;  // only reset leaves HALT
        default: state_q <= BOOT;
      endcase
    end
  end

  assign bus.imem_addr    = pc_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_instr    = out_instr_q;
  assign bus.out_pc       = out_pc_q;
  assign bus.out_pc_plus4 = out_pc_plus4_q;
  assign bus.fetch_cnt    = cnt_q;
endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst0 = 1'b1;
  logic rst1 = 1'b1;
  int   total = 0;
  int   passed = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  fetch_unit_if #(.W(32)) bus0();
  fetch_unit_if #(.W(32)) bus1();

  fetch_unit #(.RESET_PC(32'h0000_0000), .PROG_VALUE(32)) u0 (
    .clk(clk), .reset(rst0), .bus(bus0));
  fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .PROG_VALUE(32)) u1 (
    .clk(clk), .reset(rst1), .bus(bus1));

  // Instruction memory contents as a pure function of the byte address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  assign bus0.imem_rdata = mem_word(bus0.imem_addr);
  assign bus1.imem_rdata = mem_word(bus1.imem_addr);

  function automatic logic [31:0] pop_exp();
    if (exp_q.size() == 0) return 'x;
    return exp_q.pop_front();
  endfunction

  function automatic logic [96:0] out_vec(input logic [31:0] pc);
    return {1'b1, pc, mem_word(pc), pc + 32'd4};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] e;
    bus0.out_ready = 1'b1; bus0.redirect_valid = 1'b0; bus0.redirect_pc = '0;
    bus1.out_ready = 1'b1; bus1.redirect_valid = 1'b0; bus1.redirect_pc = '0;
    tick(); tick();
    total++;
    if ({bus0.out_valid, bus0.out_instr, bus0.out_pc, bus0.out_pc_plus4} !== {1'b0, 32'h13, 32'h0, 32'h0})
      $display("FAIL reset_out: got %h want %h",
               {bus0.out_valid, bus0.out_instr, bus0.out_pc, bus0.out_pc_plus4}, {1'b0, 32'h13, 64'h0});
    else passed++;
    total++;
    if ({bus0.fetch_cnt, bus0.misalign_err, bus0.imem_addr} !== {32'h0, 1'b0, 32'h0})
      $display("FAIL reset_cnt_err_addr: got %h want %h",
               {bus0.fetch_cnt, bus0.misalign_err, bus0.imem_addr}, 65'h0);
    else passed++;
    // Release reset and walk through the boot bubble into sequential fetch.
    rst0 = 1'b0;
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    tick();
    total++;
    if (bus0.out_valid !== 1'b0) $display("FAIL boot_bubble: got %b want 0", bus0.out_valid);
    else passed++;
    total++;
    if (bus0.imem_addr !== 32'h0) $display("FAIL boot_addr: got %h want 0", bus0.imem_addr);
    else passed++;
  endtask

  task automatic test_fetch_seq();
    logic [31:0] e;
    for (int i = 0; i < 3; i++) begin
      tick();
      e = pop_exp();
      total++;
      if ({bus0.out_valid, bus0.out_pc, bus0.out_instr, bus0.out_pc_plus4} !== out_vec(e))
        $display("FAIL seq_fetch%0d: got %h want %h", i,
                 {bus0.out_valid, bus0.out_pc, bus0.out_instr, bus0.out_pc_plus4}, out_vec(e));
      else passed++;
    end
  endtask

  task automatic test_stall();
    logic [31:0] e;
    bus0.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({bus0.out_valid, bus0.out_pc, bus0.out_instr, bus0.out_pc_plus4} !== out_vec(32'h8))
        $display("FAIL stall_hold%0d: got %h want %h", i,
                 {bus0.out_valid, bus0.out_pc, bus0.out_instr, bus0.out_pc_plus4}, out_vec(32'h8));
      else passed++;
      total++;
      if ({bus0.imem_addr, bus0.fetch_cnt} !== {32'hC, 32'd2})
        $display("FAIL stall_addr_cnt%0d: got %h want %h", i,
                 {bus0.imem_addr, bus0.fetch_cnt}, {32'hC, 32'd2});
      else passed++;
    end
    bus0.out_ready = 1'b1;
    exp_q.push_back(32'hC);
    tick();
    e = pop_exp();
    total++;
    if ({bus0.out_valid, bus0.out_pc, bus0.out_instr, bus0.out_pc_plus4} !== out_vec(e))
      $display("FAIL stall_release: got %h want %h",
               {bus0.out_valid, bus0.out_pc, bus0.out_instr, bus0.out_pc_plus4}, out_vec(e));
    else passed++;
    total++;
    if (bus0.fetch_cnt !== 32'd3) $display("FAIL stall_release_cnt: got %0d want 3", bus0.fetch_cnt);
    else passed++;
  endtask

  task automatic test_redirect();
    logic [31:0] e;
    // Redirect while stalled: flush, no count.
    bus0.out_ready = 1'b0; bus0.redirect_valid = 1'b1; bus0.redirect_pc = 32'h100;
    tick();
    total++;
    if ({bus0.out_valid, bus0.imem_addr, bus0.fetch_cnt} !== {1'b0, 32'h100, 32'd3})
      $display("FAIL redir_flush: got %h want %h",
               {bus0.out_valid, bus0.imem_addr, bus0.fetch_cnt}, {1'b0, 32'h100, 32'd3});
    else passed++;
    bus0.redirect_valid = 1'b0; bus0.out_ready = 1'b1;
    exp_q.push_back(32'h100);
    tick();
    e = pop_exp();
    total++;
    if ({bus0.out_valid, bus0.out_pc, bus0.out_instr, bus0.out_pc_plus4} !== out_vec(e))
      $display("FAIL redir_target: got %h want %h",
               {bus0.out_valid, bus0.out_pc, bus0.out_instr, bus0.out_pc_plus4}, out_vec(e));
    else passed++;
    // Redirect while a valid instruction is accepted: still counts.
    bus0.redirect_valid = 1'b1; bus0.redirect_pc = 32'h200;
    tick();
    total++;
    if ({bus0.out_valid, bus0.imem_addr, bus0.fetch_cnt} !== {1'b0, 32'h200, 32'd4})
      $display("FAIL redir_count: got %h want %h",
               {bus0.out_valid, bus0.imem_addr, bus0.fetch_cnt}, {1'b0, 32'h200, 32'd4});
    else passed++;
    bus0.redirect_valid = 1'b0;
    exp_q.push_back(32'h200);
    tick();
    e = pop_exp();
    total++;
    if ({bus0.out_valid, bus0.out_pc, bus0.out_instr, bus0.out_pc_plus4} !== out_vec(e))
      $display("FAIL redir_target2: got %h want %h",
               {bus0.out_valid, bus0.out_pc, bus0.out_instr, bus0.out_pc_plus4}, out_vec(e));
    else passed++;
  endtask

  task automatic test_misalign();
    logic [31:0] e;
    bus0.out_ready = 1'b1; bus0.redirect_valid = 1'b1; bus0.redirect_pc = 32'h102;
    tick();
`ifdef FETCH_MISALIGN_TRAP_EN
    total++;
    if ({bus0.misalign_err, bus0.out_valid, bus0.imem_addr, bus0.fetch_cnt} !== {1'b1, 1'b0, 32'h204, 32'd5})
      $display("FAIL misalign_trap: got %h want %h",
               {bus0.misalign_err, bus0.out_valid, bus0.imem_addr, bus0.fetch_cnt}, {1'b1, 1'b0, 32'h204, 32'd5});
    else passed++;
    // HALT ignores further redirects and never fetches.
    bus0.redirect_pc = 32'h300;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if ({bus0.misalign_err, bus0.out_valid, bus0.imem_addr} !== {1'b1, 1'b0, 32'h204})
        $display("FAIL misalign_halt%0d: got %h want %h", i,
                 {bus0.misalign_err, bus0.out_valid, bus0.imem_addr}, {1'b1, 1'b0, 32'h204});
      else passed++;
    end
    bus0.redirect_valid = 1'b0;
`else
    total++;
    if ({bus0.misalign_err, bus0.out_valid, bus0.imem_addr, bus0.fetch_cnt} !== {1'b0, 1'b0, 32'h100, 32'd5})
      $display("FAIL misalign_align: got %h want %h",
               {bus0.misalign_err, bus0.out_valid, bus0.imem_addr, bus0.fetch_cnt}, {1'b0, 1'b0, 32'h100, 32'd5});
    else passed++;
    bus0.redirect_valid = 1'b0;
    exp_q.push_back(32'h100);
    tick();
    e = pop_exp();
    total++;
    if ({bus0.out_valid, bus0.out_pc, bus0.out_instr, bus0.out_pc_plus4} !== out_vec(e))
      $display("FAIL misalign_target: got %h want %h",
               {bus0.out_valid, bus0.out_pc, bus0.out_instr, bus0.out_pc_plus4}, out_vec(e));
    else passed++;
`endif
  endtask

  task automatic test_async_reset();
    logic [31:0] e;
    bus0.out_ready = 1'b0;
    tick();
    #2;
    rst0 = 1'b1;
    #1;  // still 6 time units before the next rising edge
    exp_q.delete();
    total++;
    if ({bus0.out_valid, bus0.out_instr, bus0.out_pc, bus0.out_pc_plus4} !== {1'b0, 32'h13, 32'h0, 32'h0})
      $display("FAIL async_reset_out: got %h want %h",
               {bus0.out_valid, bus0.out_instr, bus0.out_pc, bus0.out_pc_plus4}, {1'b0, 32'h13, 64'h0});
    else passed++;
    total++;
    if ({bus0.fetch_cnt, bus0.misalign_err, bus0.imem_addr} !== 65'h0)
      $display("FAIL async_reset_cnt_err_addr: got %h want %h",
               {bus0.fetch_cnt, bus0.misalign_err, bus0.imem_addr}, 65'h0);
    else passed++;
    rst0 = 1'b0; bus0.out_ready = 1'b1;
    tick();
    total++;
    if (bus0.out_valid !== 1'b0) $display("FAIL async_reset_bubble: got %b want 0", bus0.out_valid);
    else passed++;
    exp_q.push_back(32'h0);
    tick();
    e = pop_exp();
    total++;
    if ({bus0.out_valid, bus0.out_pc, bus0.out_instr, bus0.out_pc_plus4} !== out_vec(e))
      $display("FAIL async_reset_refetch: got %h want %h",
               {bus0.out_valid, bus0.out_pc, bus0.out_instr, bus0.out_pc_plus4}, out_vec(e));
    else passed++;
  endtask

  task automatic test_wrap();
    logic [31:0] e;
    rst1 = 1'b0;
    exp_q.delete();
    exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0);
    tick();
    total++;
    if (bus1.out_valid !== 1'b0) $display("FAIL wrap_bubble: got %b want 0", bus1.out_valid);
    else passed++;
    tick();
    e = pop_exp();
    total++;
    if ({bus1.out_valid, bus1.out_pc, bus1.out_instr, bus1.out_pc_plus4} !== {1'b1, 32'hFFFF_FFFC, mem_word(e), 32'h0})
      $display("FAIL wrap_first: got %h want %h",
               {bus1.out_valid, bus1.out_pc, bus1.out_instr, bus1.out_pc_plus4}, {1'b1, 32'hFFFF_FFFC, mem_word(e), 32'h0});
    else passed++;
    tick();
    e = pop_exp();
    total++;
    if ({bus1.out_valid, bus1.out_pc, bus1.out_instr, bus1.out_pc_plus4} !== out_vec(e))
      $display("FAIL wrap_second: got %h want %h",
               {bus1.out_valid, bus1.out_pc, bus1.out_instr, bus1.out_pc_plus4}, out_vec(e));
    else passed++;
    total++;
    if (bus1.misalign_err !== 1'b0) $display("FAIL wrap_noflag: got %b want 0", bus1.misalign_err);
    else passed++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_fetch_seq();
    test_stall();
    test_redirect();
    test_misalign();
    test_async_reset();
    test_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 The block SHALL have parameter PROG_VALUE, default 32, meaning the address and instruction width.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have port imem_addr, output, 32, the byte address driven to the instruction memory read port.
REQ-006 The block SHALL have port imem_rdata, input, 32, the combinational read data returned for imem_addr in the same cycle.
REQ-007 The block SHALL have port redirect_valid, input, 1, a branch/jump redirect request.
REQ-008 The block SHALL have port redirect_pc, input, 32, the redirect target byte address.
REQ-009 The block SHALL have port out_valid, output, 1, meaning the IF/ID register holds a valid instruction.
REQ-010 The block SHALL have port out_ready, input, 1, meaning the decode stage accepts out_* this cycle.
REQ-011 The block SHALL have ports out_instr, out_pc and out_pc_plus4, each output, 32, carrying the fetched instruction, its address and its address+4.
REQ-012 The block SHALL have port fetch_cnt, output, 32, a count of instructions accepted by decode.
REQ-013 The block SHALL have port misalign_err, output, 1, a sticky misaligned-redirect flag.

Function
REQ-014 The block SHALL drive imem_addr combinationally from the internal register pc_q.
REQ-015 The block SHALL implement FSM states BOOT, RUN and HALT; reset SHALL enter BOOT, BOOT SHALL go to RUN after one cycle, and HALT SHALL be left only by reset.
REQ-016 The block SHALL perform no fetch in BOOT; it SHALL provide exactly one bubble cycle after reset deassertion.
REQ-017 In RUN with redirect_valid=0 and (out_valid=0 or out_ready=1), the block SHALL load out_instr<=imem_rdata, out_pc<=pc_q, out_pc_plus4<=pc_q+4 and out_valid<=1, and SHALL set pc_q<=pc_q+4.
REQ-018 In RUN with out_valid=1, out_ready=0 and redirect_valid=0, the block SHALL hold all out_* and pc_q unchanged.
REQ-019 A redirect SHALL have priority over stall and fetch: in RUN with redirect_valid=1, the block SHALL set pc_q<=redirect_pc and out_valid<=0, capture nothing that cycle, and resume fetching from the target on the next cycle.
REQ-020 The block SHALL ignore redirect_valid in BOOT and HALT.
REQ-021 The block SHALL increment fetch_cnt by 1 in every cycle in which out_valid=1 and out_ready=1, including redirect cycles, with modulo-2^32 wrap.
REQ-022 The block SHALL compute pc arithmetic modulo 2^32, so that 32'hFFFF_FFFC+4 yields 32'h0000_0000 with no flag.
REQ-023 Latency SHALL be one cycle from pc_q being presented on imem_addr to out_valid with the corresponding out_instr.

Reset
REQ-024 While reset=1, the block SHALL set pc_q=RESET_PC, state=BOOT, out_valid=0, out_instr=32'h0000_0013 (NOP), out_pc=0, out_pc_plus4=0, fetch_cnt=0 and misalign_err=0, asynchronously and independent of clk.
REQ-025 Reset asserted mid-stall or mid-redirect SHALL discard all pending state; no partial capture SHALL survive.

Configuration
REQ-026 The block SHALL use macro FETCH_MISALIGN_TRAP_EN to select redirect alignment handling.
REQ-027 When FETCH_MISALIGN_TRAP_EN is defined, a RUN-state redirect with redirect_pc[1:0]!=0 SHALL set misalign_err=1, leave pc_q unchanged, clear out_valid and move the FSM to HALT.
REQ-028 When FETCH_MISALIGN_TRAP_EN is undefined, the block SHALL load redirect_pc[1:0] into pc_q as 2'b00, and misalign_err SHALL be tied to 0.

Verification
REQ-029 The bench SHALL check: reset released with RESET_PC=0 and out_ready=1 -> out_valid=0 in the BOOT cycle, then out_pc=0,4,8 on consecutive cycles, with out_instr equal to memory words 0,1,2.
REQ-030 The bench SHALL check: out_ready=0 for 3 cycles while out_pc=8 -> out_* and imem_addr=12 held, fetch_cnt unchanged; out_ready=1 -> out_pc=12 next cycle.
REQ-031 The bench SHALL check: redirect_valid=1 with redirect_pc=0x100 while out_ready=0 -> out_valid=0 next cycle, then out_pc=0x100.
REQ-032 The bench SHALL check: RESET_PC=32'hFFFF_FFFC -> first out_pc=0xFFFFFFFC, out_pc_plus4=0, and next out_pc=0.
REQ-033 The bench SHALL check: redirect_pc=0x102 with the macro defined -> misalign_err=1, HALT, out_valid stays 0; with the macro undefined -> out_pc=0x100.
REQ-034 The bench SHALL check: reset asserted asynchronously mid-stall -> all outputs reach their reset values before the next clk edge.
